// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- handshaked ALU with a registered single-cycle path and an
// iterative (one bit per cycle) multiplier and optional unsigned divider.
//
// Compile-time option:
//   ALU_DIV_EN  when defined, DIVU/REMU are built and executed iteratively;
//               when undefined, the divider is not built and opcodes
//               01100/01101 decode as illegal.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   enable          global hold; 0 freezes every register
//   in_valid/ready  upstream handshake carrying opcode, a, b
//   out_valid/ready downstream handshake carrying out and flags
//   out             WIDTH-bit result
//   zero            out == 0
//   carry           ADD carry out / SUB inverted borrow, else 0
//   ovf             ADD/SUB signed overflow, else 0
//   dz              DIVU/REMU with b == 0
//   illegal         unsupported opcode
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz,
    output logic             illegal
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SLL  = 5'b00110;
    localparam logic [4:0] OP_SRL  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01000;
    localparam logic [4:0] OP_SLT  = 5'b01001;
    localparam logic [4:0] OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01011;
`ifdef ALU_DIV_EN
    localparam logic [4:0] OP_DIVU = 5'b01100;
    localparam logic [4:0] OP_REMU = 5'b01101;

    localparam logic [1:0] KIND_MUL  = 2'd0;
    localparam logic [1:0] KIND_DIVU = 2'd1;
    localparam logic [1:0] KIND_REMU = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    // Shared iterative operands:
    //   MUL : acc = partial product, opa = shifted multiplicand, opb = shifted multiplier
    //   DIV : acc = partial remainder, opa = dividend shifting out / quotient shifting in,
    //         opb = divisor
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
`ifdef ALU_DIV_EN
    logic [1:0]       kind_reg;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;

    assign in_ready = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    assign accept   = enable && in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     dif_ext;
    logic [CNT_W-2:0]   shamt;
    logic [WIDTH-1:0]   res_comb;
    logic               carry_comb;
    logic               ovf_comb;
    logic               illegal_comb;
    logic               iter_comb;

    assign shamt   = b[CNT_W-2:0];
    assign sum_ext = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the top bit is the inverted borrow
    assign dif_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res_comb     = '0;
        carry_comb   = 1'b0;
        ovf_comb     = 1'b0;
        illegal_comb = 1'b0;
        iter_comb    = 1'b0;
        case (opcode)
            OP_ADD: begin
                res_comb   = sum_ext[WIDTH-1:0];
                carry_comb = sum_ext[WIDTH];
                ovf_comb   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_comb   = dif_ext[WIDTH-1:0];
                carry_comb = dif_ext[WIDTH];
                ovf_comb   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_comb = a & b;
            OP_OR:   res_comb = a | b;
            OP_XOR:  res_comb = a ^ b;
            OP_NOT:  res_comb = ~a;
            OP_SLL:  res_comb = a << shamt;
            OP_SRL:  res_comb = a >> shamt;
            OP_SRA:  res_comb = $unsigned($signed(a) >>> shamt);
            OP_SLT:  res_comb = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res_comb = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MUL:  iter_comb = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIVU, OP_REMU: iter_comb = 1'b1;
`endif
            default: illegal_comb = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath: one step per enabled BUSY cycle
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_opa;
    logic [WIDTH-1:0] step_opb;
    logic [WIDTH-1:0] fin_res;
    logic             fin_dz;

    assign mul_sum = acc_reg + (opb_reg[0] ? opa_reg : '0);

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_tmp;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    // Restoring division: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. With b == 0 every step "fits", which
    // naturally yields quotient = all ones and remainder = a.
    assign div_tmp = {acc_reg, opa_reg[WIDTH-1]};
    assign div_ge  = (div_tmp >= {1'b0, opb_reg});
    assign div_rem = div_ge ? WIDTH'(div_tmp - {1'b0, opb_reg}) : div_tmp[WIDTH-1:0];

    always_comb begin
        step_acc = mul_sum;
        step_opa = opa_reg << 1;
        step_opb = opb_reg >> 1;
        fin_res  = mul_sum;
        fin_dz   = 1'b0;
        case (kind_reg)
            KIND_DIVU: begin
                step_acc = div_rem;
                step_opa = {opa_reg[WIDTH-2:0], div_ge};
                step_opb = opb_reg;
                fin_res  = {opa_reg[WIDTH-2:0], div_ge};
                fin_dz   = (opb_reg == '0);
            end
            KIND_REMU: begin
                step_acc = div_rem;
                step_opa = {opa_reg[WIDTH-2:0], div_ge};
                step_opb = opb_reg;
                fin_res  = div_rem;
                fin_dz   = (opb_reg == '0);
            end
            default: ;
        endcase
    end
`else
    assign step_acc = mul_sum;
    assign step_opa = opa_reg << 1;
    assign step_opb = opb_reg >> 1;
    assign fin_res  = mul_sum;
    assign fin_dz   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            acc_reg   <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
`ifdef ALU_DIV_EN
            kind_reg  <= KIND_MUL;
`endif
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            illegal   <= 1'b0;
        end else if (enable) begin
            case (state_reg)
                ST_BUSY: begin
                    count_reg <= count_reg - CNT_W'(1);
                    acc_reg   <= step_acc;
                    opa_reg   <= step_opa;
                    opb_reg   <= step_opb;
                    // count_reg == 1 means this edge performs the last step
                    if (count_reg == CNT_W'(1)) begin
                        state_reg <= ST_DONE;
                        out_valid <= 1'b1;
                        out       <= fin_res;
                        zero      <= (fin_res == '0);
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        dz        <= fin_dz;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        if (iter_comb) begin
                            state_reg <= ST_BUSY;
                            count_reg <= CNT_W'(WIDTH);
                            acc_reg   <= '0;
                            opa_reg   <= a;
                            opb_reg   <= b;
`ifdef ALU_DIV_EN
                            kind_reg  <= (opcode == OP_MUL)  ? KIND_MUL  :
                                         (opcode == OP_DIVU) ? KIND_DIVU : KIND_REMU;
`endif
                            out_valid <= 1'b0;
                        end else begin
                            state_reg <= ST_DONE;
                            out_valid <= 1'b1;
                            out       <= res_comb;
                            zero      <= (res_comb == '0);
                            carry     <= carry_comb;
                            ovf       <= ovf_comb;
                            dz        <= 1'b0;
                            illegal   <= illegal_comb;
                        end
                    end else if ((state_reg == ST_DONE) && out_ready) begin
                        state_reg <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH = 32).
// Hand-derived vector table, hand-written handshake/stall/reset sequences and
// randomized operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 32;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam longint TWO_W = longint'(1) << W;
    localparam longint MAXS  = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS  = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         dz;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .dz        (dz),
        .illegal   (illegal)
    );

    // flags = {zero, carry, ovf, dz, illegal}
    typedef struct packed {
        logic [W-1:0] out;
        logic [4:0]   flags;
    } exp_t;

    typedef struct packed {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    vec_t vecs[$];

    // ------------------------------------------------------------------
    // Reference model: plain arithmetic on wide signed/unsigned integers
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        longint       sx;
        longint       sy;
        longint       sr;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         d;
        logic         il;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        c  = 1'b0;
        o  = 1'b0;
        d  = 1'b0;
        il = 1'b0;
        case (op)
            5'd0: begin
                r  = x + y;
                c  = (longint'(x) + longint'(y)) >= TWO_W;
                sr = sx + sy;
                o  = (sr > MAXS) || (sr < MINS);
            end
            5'd1: begin
                r  = x - y;
                c  = (x >= y);
                sr = sx - sy;
                o  = (sr > MAXS) || (sr < MINS);
            end
            5'd2:  r = x & y;
            5'd3:  r = x | y;
            5'd4:  r = x ^ y;
            5'd5:  r = ~x;
            5'd6:  r = x << y[4:0];
            5'd7:  r = x >> y[4:0];
            5'd8:  r = W'(sx >>> y[4:0]);
            5'd9:  r = (sx < sy) ? W'(1) : W'(0);
            5'd10: r = (x < y) ? W'(1) : W'(0);
            5'd11: r = W'(longint'(x) * longint'(y));
            5'd12: begin
                if (!DIV_EN) il = 1'b1;
                else if (y == '0) begin r = '1; d = 1'b1; end
                else r = x / y;
            end
            5'd13: begin
                if (!DIV_EN) il = 1'b1;
                else if (y == '0) begin r = x; d = 1'b1; end
                else r = x % y;
            end
            default: il = 1'b1;
        endcase
        e.out   = r;
        e.flags = {(r == '0), c, o, d, il};
        return e;
    endfunction

    function automatic bit is_iter(input logic [4:0] op);
        return (op == 5'd11) || (DIV_EN && ((op == 5'd12) || (op == 5'd13)));
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] r, input logic [4:0] f);
        vec_t v;
        v.op      = op;
        v.a       = x;
        v.b       = y;
        v.e.out   = r;
        v.e.flags = f;
        return v;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 40);
            2: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h0000_0000;
                    1: v = 32'hFFFF_FFFF;
                    2: v = 32'h8000_0000;
                    default: v = 32'h7FFF_FFFF;
                endcase
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", W'(in_ready), 1);
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until out_valid, and how many of
    // those cycles showed in_ready high.
    task automatic wait_valid(output int lat, output int rdy_seen);
        lat      = 0;
        rdy_seen = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen++;
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_valid", W'(out_valid), 0);
    endtask

    task automatic run_txn(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                           input exp_t e, input int stall);
        int lat;
        int rdy;
        issue(op, x, y);
        wait_valid(lat, rdy);
        chk("latency", lat, is_iter(op) ? W : 0);
        chk("busy_in_ready", rdy, 0);
        chk("out", out, e.out);
        chk("flags", W'({zero, carry, ovf, dz, illegal}), W'(e.flags));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_out", out, e.out);
            chk("stall_valid", W'(out_valid), 1);
        end
        $display("TXN op=%02h a=%08h b=%08h out=%08h flags=%05b lat=%0d",
                 op, x, y, out, {zero, carry, ovf, dz, illegal}, lat);
        consume();
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int           lat;
        int           rdy;
        logic [4:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;

        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", W'(out_valid), 0);
        chk("reset_out", out, 0);
        chk("reset_flags", W'({zero, carry, ovf, dz, illegal}), 0);
        chk("reset_in_ready", W'(in_ready), 1);
        $display("TXN reset out_valid=%0d in_ready=%0d", out_valid, in_ready);
        rst = 1'b0;
        tick();

        // ---------------- vector table (flags = z c o d i) ----------------
        vecs.push_back(mk(5'd0,  32'h0F0F0F0F, 32'h70F0F0F0, 32'h7FFFFFFF, 5'b00000));
        vecs.push_back(mk(5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00100));
        vecs.push_back(mk(5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b11000));
        vecs.push_back(mk(5'd1,  32'h00000005, 32'h00000005, 32'h00000000, 5'b11000));
        vecs.push_back(mk(5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b00000));
        vecs.push_back(mk(5'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b01100));
        vecs.push_back(mk(5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00000));
        vecs.push_back(mk(5'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000));
        vecs.push_back(mk(5'd4,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 5'b00000));
        vecs.push_back(mk(5'd5,  32'h00000000, 32'h12345678, 32'hFFFFFFFF, 5'b00000));
        vecs.push_back(mk(5'd5,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5'b10000));
        vecs.push_back(mk(5'd6,  32'h00000001, 32'h0000001F, 32'h80000000, 5'b00000));
        vecs.push_back(mk(5'd6,  32'h00000003, 32'h00000021, 32'h00000006, 5'b00000));
        vecs.push_back(mk(5'd7,  32'h80000000, 32'h0000001F, 32'h00000001, 5'b00000));
        vecs.push_back(mk(5'd8,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 5'b00000));
        vecs.push_back(mk(5'd8,  32'h40000000, 32'h0000001E, 32'h00000001, 5'b00000));
        vecs.push_back(mk(5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000));
        vecs.push_back(mk(5'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b10000));
        vecs.push_back(mk(5'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000));
        vecs.push_back(mk(5'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5'b00000));
        vecs.push_back(mk(5'd11, 32'h00012345, 32'h00000100, 32'h01234500, 5'b00000));
        vecs.push_back(mk(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'b00000));
`ifdef ALU_DIV_EN
        vecs.push_back(mk(5'd12, 32'd100,      32'd7,        32'd14,       5'b00000));
        vecs.push_back(mk(5'd13, 32'd100,      32'd7,        32'd2,        5'b00000));
        vecs.push_back(mk(5'd12, 32'd9,        32'd0,        32'hFFFFFFFF, 5'b00010));
        vecs.push_back(mk(5'd13, 32'd9,        32'd0,        32'd9,        5'b00010));
        vecs.push_back(mk(5'd13, 32'd21,       32'd7,        32'd0,        5'b10000));
`else
        vecs.push_back(mk(5'd12, 32'd100,      32'd7,        32'd0,        5'b10001));
        vecs.push_back(mk(5'd13, 32'd100,      32'd7,        32'd0,        5'b10001));
`endif
        vecs.push_back(mk(5'd31, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10001));
        vecs.push_back(mk(5'd14, 32'h00000001, 32'h00000001, 32'h00000000, 5'b10001));

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1);
        end

        // ---------------- XOR held result, then back-to-back accept ----------------
        issue(5'd4, 32'hA5A5A5A5, 32'h0F0F0F0F);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out", out, 32'hAAAAAAAA);
            chk("hold_flags", W'({zero, carry, ovf, dz, illegal}), 0);
            chk("hold_in_ready", W'(in_ready), 0);
            chk("hold_valid", W'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        opcode    = 5'd0;
        a         = 32'd1;
        b         = 32'd2;
        in_valid  = 1'b1;
        #1;
        chk("b2b_in_ready", W'(in_ready), 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid", W'(out_valid), 1);
        chk("b2b_out", out, 32'd3);
        $display("TXN xor-hold then back-to-back add out=%08h", out);
        consume();

        // ---------------- MUL with in_valid held during BUSY ----------------
        issue(5'd11, 32'h00012345, 32'h00000100);
        opcode   = 5'd0;
        a        = 32'd1;
        b        = 32'd1;
        in_valid = 1'b1;
        wait_valid(lat, rdy);
        in_valid = 1'b0;
        chk("mulhold_latency", lat, W);
        chk("mulhold_in_ready", rdy, 0);
        chk("mulhold_out", out, 32'h01234500);
        $display("TXN mul with in_valid held out=%08h lat=%0d", out, lat);
        consume();

        // ---------------- enable stall mid-MUL ----------------
        issue(5'd11, 32'h00001234, 32'h00000011);
        repeat (5) tick();
        enable = 1'b0;
        repeat (3) tick();
        chk("enstall_valid", W'(out_valid), 0);
        chk("enstall_in_ready", W'(in_ready), 0);
        enable = 1'b1;
        wait_valid(lat, rdy);
        chk("enstall_latency", 8 + lat, W + 3);
        chk("enstall_out", out, 32'h00013574);
        // out_ready must be ignored while enable is low
        enable    = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("enstall_ready_ignored", W'(out_valid), 1);
        enable = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("enstall_drain", W'(out_valid), 0);
        $display("TXN mul with 3 disabled cycles out=%08h lat=%0d", out, 8 + lat);

        // ---------------- reset mid-iteration ----------------
        run_txn(5'd0, 32'd1, 32'd1, model(5'd0, 32'd1, 32'd1), 0);
        issue(DIV_EN ? 5'd12 : 5'd11, 32'd1000, 32'd3);
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", W'(out_valid), 0);
        chk("midrst_out", out, 0);
        chk("midrst_in_ready", W'(in_ready), 1);
        chk("midrst_flags", W'({zero, carry, ovf, dz, illegal}), 0);
        $display("TXN reset during iterative op out_valid=%0d in_ready=%0d", out_valid, in_ready);
        #1;
        rst = 1'b0;
        tick();
        run_txn(5'd1, 32'd10, 32'd3, model(5'd1, 32'd10, 32'd3), 0);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 250; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            x  = pick();
            y  = pick();
            run_txn(op, x, y, model(op, x, y), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
